// File: rtl/piso_serial_tx_ctrl_if.sv
// Handshake and serial-line bundle for piso_serial_tx_ctrl.
// The master side is the parallel word producer (it also owns the hold request).
// The slave side is the serialiser controller.
interface piso_serial_tx_ctrl_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] i_d;
  logic             i_valid;
  logic             o_ready;
  logic             i_hold;
  logic             o_sdata;
  logic             o_sframe;
  logic             o_done;
  logic             o_busy;

  modport master (
    output i_d,
    output i_valid,
    output i_hold,
    input  o_ready,
    input  o_sdata,
    input  o_sframe,
    input  o_done,
    input  o_busy
  );

  modport slave (
    input  i_d,
    input  i_valid,
    input  i_hold,
    output o_ready,
    output o_sdata,
    output o_sframe,
    output o_done,
    output o_busy
  );

endinterface : piso_serial_tx_ctrl_if

// File: rtl/piso_serial_tx_ctrl.sv
// Parallel-in / serial-out transmit controller.
// Accepts a WIDTH-bit word over valid/ready and shifts it out one bit per clock
// with a frame strobe. After the last bit it inserts GAP_CYCLES idle cycles.
// i_hold freezes the shift register and bit counter while a word is in flight.
// o_sdata, o_sframe, o_ready and o_busy come straight from flops.
// o_done also depends on the live i_hold, so that a held last bit does not pulse.
module piso_serial_tx_ctrl #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  piso_serial_tx_ctrl_if.slave    bus
);

  // Counter widths. The gap counter keeps one bit even when no gap is configured.
  localparam int BCW = $clog2(WIDTH + 1);
  localparam int GCW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam int unsigned BIT_LAST_I = WIDTH - 1;
  localparam int unsigned GAP_LAST_I = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;
  localparam logic [BCW-1:0] BIT_LAST = BIT_LAST_I[BCW-1:0];
  localparam logic [GCW-1:0] GAP_LAST = GAP_LAST_I[GCW-1:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] shreg_q,  shreg_d;
  logic [BCW-1:0]   bitcnt_q, bitcnt_d;
  logic [GCW-1:0]   gapcnt_q, gapcnt_d;
  logic             sdata_q,  sdata_d;
  logic             sframe_q, sframe_d;
  logic             ready_q,  ready_d;
  logic             busy_q,   busy_d;

  // Bit currently presented on the wire, taken from the selected end of the word.
  function automatic logic out_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return w[WIDTH-1];
    end else begin
      return w[0];
    end
  endfunction

  // Move the next bit to the output end; the vacated end is filled with zero.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return {w[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, w[WIDTH-1:1]};
    end
  endfunction

  // Next-state, datapath and registered-output decode for the IDLE/SHIFT/GAP sequencer.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;

    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          shreg_d  = bus.i_d;
          bitcnt_d = '0;
          state_d  = SHIFT;
        end else begin
          state_d  = IDLE;
        end
      end

      SHIFT: begin
        if (bus.i_hold) begin
          // Paused: word, position and line all stay as they are.
          state_d = SHIFT;
        end else if (bitcnt_q == BIT_LAST) begin
          shreg_d  = shift_once(shreg_q);
          bitcnt_d = '0;
          if (GAP_CYCLES > 0) begin
            gapcnt_d = '0;
            state_d  = GAP;
          end else begin
            state_d  = IDLE;
          end
        end else begin
          shreg_d  = shift_once(shreg_q);
          bitcnt_d = bitcnt_q + BCW'(1);
          state_d  = SHIFT;
        end
      end

      GAP: begin
        // Hold has no meaning between words, so the gap always runs to completion.
        if (gapcnt_q == GAP_LAST) begin
          gapcnt_d = '0;
          state_d  = IDLE;
        end else begin
          gapcnt_d = gapcnt_q + GCW'(1);
          state_d  = GAP;
        end
      end

      default: begin
        state_d  = IDLE;
        shreg_d  = '0;
        bitcnt_d = '0;
        gapcnt_d = '0;
      end
    endcase

    // Outputs are decoded from the next state so they leave the flops aligned with it.
    ready_d  = (state_d == IDLE);
    busy_d   = !ready_d;
    sframe_d = (state_d == SHIFT);
    if (sframe_d) begin
      sdata_d = out_bit(shreg_d);
    end else begin
      sdata_d = 1'b0;
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
      sdata_q  <= 1'b0;
      sframe_q <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
      sdata_q  <= sdata_d;
      sframe_q <= sframe_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.o_ready  = ready_q;
  assign bus.o_busy   = busy_q;
  assign bus.o_sframe = sframe_q;
  assign bus.o_sdata  = sdata_q;
  assign bus.o_done   = (state_q == SHIFT) && (bitcnt_q == BIT_LAST) && !bus.i_hold;

endmodule : piso_serial_tx_ctrl

// File: tb/tb_piso_serial_tx_ctrl.sv
// Directed self-checking bench for piso_serial_tx_ctrl.
// Four instances cover: LSB-first with a 1-cycle gap, MSB-first, a 2-cycle gap and no gap.
module tb_piso_serial_tx_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  piso_serial_tx_ctrl_if #(.WIDTH(4)) if0 ();
  piso_serial_tx_ctrl_if #(.WIDTH(4)) if1 ();
  piso_serial_tx_ctrl_if #(.WIDTH(4)) if2 ();
  piso_serial_tx_ctrl_if #(.WIDTH(4)) if3 ();

  piso_serial_tx_ctrl #(.WIDTH(4), .GAP_CYCLES(1), .MSB_FIRST(1'b0)) dut0 (.i_clk(clk), .i_rst(rst), .bus(if0.slave));
  piso_serial_tx_ctrl #(.WIDTH(4), .GAP_CYCLES(1), .MSB_FIRST(1'b1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(if1.slave));
  piso_serial_tx_ctrl #(.WIDTH(4), .GAP_CYCLES(2), .MSB_FIRST(1'b0)) dut2 (.i_clk(clk), .i_rst(rst), .bus(if2.slave));
  piso_serial_tx_ctrl #(.WIDTH(4), .GAP_CYCLES(0), .MSB_FIRST(1'b0)) dut3 (.i_clk(clk), .i_rst(rst), .bus(if3.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    if0.i_d = 4'h0; if0.i_valid = 1'b0; if0.i_hold = 1'b0;
    if1.i_d = 4'h0; if1.i_valid = 1'b0; if1.i_hold = 1'b0;
    if2.i_d = 4'h0; if2.i_valid = 1'b0; if2.i_hold = 1'b0;
    if3.i_d = 4'h0; if3.i_valid = 1'b0; if3.i_hold = 1'b0;

    // Power-up reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready0",  if0.o_ready,  1'b1);
    chk("rst_busy0",   if0.o_busy,   1'b0);
    chk("rst_sframe0", if0.o_sframe, 1'b0);
    chk("rst_sdata0",  if0.o_sdata,  1'b0);
    chk("rst_done0",   if0.o_done,   1'b0);
    chk("rst_ready1",  if1.o_ready,  1'b1);
    chk("rst_ready2",  if2.o_ready,  1'b1);
    chk("rst_ready3",  if3.o_ready,  1'b1);

    // Basic LSB-first, 4'b1010 -> 0,1,0,1 then 1 gap cycle
    if0.i_d = 4'b1010; if0.i_valid = 1'b1;
    tick();
    if0.i_valid = 1'b0; if0.i_d = 4'b0000;
    chk("b_c1_sdata",  if0.o_sdata,  1'b0);
    chk("b_c1_sframe", if0.o_sframe, 1'b1);
    chk("b_c1_busy",   if0.o_busy,   1'b1);
    chk("b_c1_ready",  if0.o_ready,  1'b0);
    chk("b_c1_done",   if0.o_done,   1'b0);
    tick();
    chk("b_c2_sdata",  if0.o_sdata,  1'b1);
    chk("b_c2_done",   if0.o_done,   1'b0);
    tick();
    chk("b_c3_sdata",  if0.o_sdata,  1'b0);
    tick();
    chk("b_c4_sdata",  if0.o_sdata,  1'b1);
    chk("b_c4_sframe", if0.o_sframe, 1'b1);
    chk("b_c4_done",   if0.o_done,   1'b1);
    tick();
    chk("b_gap_sframe", if0.o_sframe, 1'b0);
    chk("b_gap_sdata",  if0.o_sdata,  1'b0);
    chk("b_gap_ready",  if0.o_ready,  1'b0);
    chk("b_gap_busy",   if0.o_busy,   1'b1);
    chk("b_gap_done",   if0.o_done,   1'b0);
    tick();
    chk("b_idle_ready", if0.o_ready, 1'b1);
    chk("b_idle_busy",  if0.o_busy,  1'b0);

    // Hold for 3 cycles after the 2nd bit of 4'b1010; frame length 7
    if0.i_d = 4'b1010; if0.i_valid = 1'b1;
    tick();
    if0.i_valid = 1'b0;
    chk("h_c1_sdata", if0.o_sdata, 1'b0);
    tick();
    if0.i_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("h_held_sdata",  if0.o_sdata,  1'b1);
      chk("h_held_sframe", if0.o_sframe, 1'b1);
      chk("h_held_done",   if0.o_done,   1'b0);
      tick();
    end
    if0.i_hold = 1'b0;
    chk("h_c5_sdata",  if0.o_sdata,  1'b1);
    chk("h_c5_sframe", if0.o_sframe, 1'b1);
    chk("h_c5_done",   if0.o_done,   1'b0);
    tick();
    chk("h_c6_sdata",  if0.o_sdata,  1'b0);
    chk("h_c6_done",   if0.o_done,   1'b0);
    tick();
    chk("h_c7_sdata",  if0.o_sdata,  1'b1);
    chk("h_c7_sframe", if0.o_sframe, 1'b1);
    chk("h_c7_done",   if0.o_done,   1'b1);
    tick();
    chk("h_c8_sframe", if0.o_sframe, 1'b0);
    tick();
    chk("h_c9_ready",  if0.o_ready,  1'b1);

    // Reset asserted for 2 cycles in the middle of a word
    if0.i_d = 4'b1010; if0.i_valid = 1'b1;
    tick();
    if0.i_valid = 1'b0;
    tick();
    chk("r_mid_sframe", if0.o_sframe, 1'b1);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("r_sframe", if0.o_sframe, 1'b0);
    chk("r_sdata",  if0.o_sdata,  1'b0);
    chk("r_ready",  if0.o_ready,  1'b1);
    chk("r_busy",   if0.o_busy,   1'b0);
    tick();
    chk("r_after_sframe", if0.o_sframe, 1'b0);
    chk("r_after_ready",  if0.o_ready,  1'b1);

    // MSB-first, 4'b1100 -> 1,1,0,0
    if1.i_d = 4'b1100; if1.i_valid = 1'b1;
    tick();
    if1.i_valid = 1'b0;
    chk("m_c1_sdata", if1.o_sdata, 1'b1);
    tick();
    chk("m_c2_sdata", if1.o_sdata, 1'b1);
    tick();
    chk("m_c3_sdata", if1.o_sdata, 1'b0);
    chk("m_c3_done",  if1.o_done,  1'b0);
    tick();
    chk("m_c4_sdata", if1.o_sdata, 1'b0);
    chk("m_c4_done",  if1.o_done,  1'b1);
    tick();
    chk("m_gap_sframe", if1.o_sframe, 1'b0);
    tick();
    chk("m_idle_ready", if1.o_ready, 1'b1);

    // MSB-first 4'b0001 with hold on the last bit: done waits for release
    if1.i_d = 4'b0001; if1.i_valid = 1'b1;
    tick();
    if1.i_valid = 1'b0;
    chk("ml_c1_sdata", if1.o_sdata, 1'b0);
    tick(); tick(); tick();
    chk("ml_c4_sdata", if1.o_sdata, 1'b1);
    chk("ml_c4_done",  if1.o_done,  1'b1);
    if1.i_hold = 1'b1;
    #1;
    chk("ml_held_done", if1.o_done, 1'b0);
    tick();
    chk("ml_held_sdata",  if1.o_sdata,  1'b1);
    chk("ml_held_sframe", if1.o_sframe, 1'b1);
    chk("ml_held2_done",  if1.o_done,   1'b0);
    if1.i_hold = 1'b0;
    #1;
    chk("ml_rel_done", if1.o_done, 1'b1);
    tick();
    chk("ml_gap_sframe", if1.o_sframe, 1'b0);
    tick();
    chk("ml_idle_ready", if1.o_ready, 1'b1);

    // Back-to-back with valid held high, GAP_CYCLES=2: 4'h5 then 4'h9
    if2.i_d = 4'h5; if2.i_valid = 1'b1;
    tick();
    if2.i_d = 4'h9;
    chk("bb_c1_sdata", if2.o_sdata, 1'b1);
    chk("bb_c1_ready", if2.o_ready, 1'b0);
    tick();
    chk("bb_c2_sdata", if2.o_sdata, 1'b0);
    tick();
    chk("bb_c3_sdata", if2.o_sdata, 1'b1);
    tick();
    chk("bb_c4_sdata", if2.o_sdata, 1'b0);
    chk("bb_c4_done",  if2.o_done,  1'b1);
    tick();
    chk("bb_g1_sframe", if2.o_sframe, 1'b0);
    chk("bb_g1_ready",  if2.o_ready,  1'b0);
    tick();
    chk("bb_g2_sframe", if2.o_sframe, 1'b0);
    chk("bb_g2_ready",  if2.o_ready,  1'b0);
    tick();
    chk("bb_idle_sframe", if2.o_sframe, 1'b0);
    chk("bb_idle_ready",  if2.o_ready,  1'b1);
    tick();
    if2.i_valid = 1'b0;
    chk("bb2_c1_sdata",  if2.o_sdata,  1'b1);
    chk("bb2_c1_sframe", if2.o_sframe, 1'b1);
    tick();
    chk("bb2_c2_sdata", if2.o_sdata, 1'b0);
    tick();
    chk("bb2_c3_sdata", if2.o_sdata, 1'b0);
    tick();
    chk("bb2_c4_sdata", if2.o_sdata, 1'b1);
    chk("bb2_c4_done",  if2.o_done,  1'b1);
    tick();
    chk("bb2_g1_ready", if2.o_ready, 1'b0);
    tick();
    chk("bb2_g2_ready", if2.o_ready, 1'b0);
    tick();
    chk("bb2_idle_ready", if2.o_ready, 1'b1);

    // GAP_CYCLES=0: 4'b0110 -> 0,1,1,0, ready the cycle after done
    if3.i_d = 4'b0110; if3.i_valid = 1'b1;
    tick();
    if3.i_valid = 1'b0;
    chk("ng_c1_sdata", if3.o_sdata, 1'b0);
    tick();
    chk("ng_c2_sdata", if3.o_sdata, 1'b1);
    tick();
    chk("ng_c3_sdata", if3.o_sdata, 1'b1);
    tick();
    chk("ng_c4_sdata", if3.o_sdata, 1'b0);
    chk("ng_c4_done",  if3.o_done,  1'b1);
    tick();
    chk("ng_ready",  if3.o_ready,  1'b1);
    chk("ng_busy",   if3.o_busy,   1'b0);
    chk("ng_sframe", if3.o_sframe, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_piso_serial_tx_ctrl
